// File: rtl/scene_pkg.sv
// Shared constants for the scene controller: scene indices, menu row geometry,
// the request FSM states and the 16-entry palette table.
package scene_pkg;

    localparam int MENU    = 0;
    localparam int GAME    = 1;
    localparam int CREDITS = 2;

    localparam int X0        = 362;
    localparam int X1        = 674;
    localparam int Y0        = 46;
    localparam int ROW_H     = 100;
    localparam int ROW_PITCH = 192;

    typedef enum logic {IDLE, PEND} req_state_t;

    // Each entry is {color1, color2}, 12 bits apiece.
    localparam logic [0:15][23:0] PALETTE = '{
        24'h000fff, 24'h099f66, 24'h9096f6, 24'h99066f,
        24'h339ff6, 24'h9336ff, 24'h393f6f, 24'hfff000,
        24'h555aaa, 24'ha5005a, 24'h0a5a05, 24'h5a050a,
        24'h00fff0, 24'h0f0f0f, 24'hf000ff, 24'h888111
    };

    function automatic logic row_hit(input int x, input int y, input int k);
        return (x >= X0) && (x <= X1) &&
               (y >= Y0 + ROW_PITCH*k) && (y <= Y0 + ROW_H + ROW_PITCH*k);
    endfunction

endpackage

// File: rtl/scene_palette_rom.sv
// Combinational palette lookup; indices past the populated range fall back to entry 0.
module scene_palette_rom
    import scene_pkg::*;
#(
    parameter int N_PAL = 7,
    parameter int RGB_W = 12
) (
    input  logic [3:0]       idx,
    output logic [RGB_W-1:0] color1,
    output logic [RGB_W-1:0] color2
);

    logic [23:0] entry;

    always_comb begin
        entry = PALETTE[0];
        if (int'(idx) < N_PAL)
            entry = PALETTE[idx];
    end

    assign color1 = RGB_W'(entry[23:12]);
    assign color2 = RGB_W'(entry[11:0]);

endmodule

// File: rtl/scene_ctl.sv
// Scene controller: menu click decoding, vblank-aligned scene switching,
// difficulty/palette selection and the registered per-scene video mux.
module scene_ctl
    import scene_pkg::*;
#(
    parameter  int N_SCENES = 3,
    parameter  int N_PAL    = 7,
    parameter  int N_DIFF   = 2,
    parameter  int RGB_W    = 12,
    localparam int SCENE_W  = $clog2(N_SCENES),
    localparam int DIFF_W   = (N_DIFF > 1) ? $clog2(N_DIFF) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vblnk_in,
    input  logic [11:0]               xpos,
    input  logic [11:0]               ypos,
    input  logic                      mouse_left,
    input  logic                      button,
    input  logic [N_SCENES*RGB_W-1:0] rgb_bus,
    input  logic [N_SCENES-1:0]       vsync_bus,
    input  logic [N_SCENES-1:0]       hsync_bus,
    output logic [RGB_W-1:0]          rgb_out,
    output logic                      vsync_out,
    output logic                      hsync_out,
    output logic [SCENE_W-1:0]        scene,
    output logic [DIFF_W-1:0]         difficulty,
    output logic [RGB_W-1:0]          color1,
    output logic [RGB_W-1:0]          color2,
    output logic                      scene_chg
);

    // Rows 0..2 always exist; extra scenes add rows 3..N_SCENES.
    localparam int N_ROWS = (N_SCENES >= 3) ? N_SCENES + 1 : 3;

    req_state_t         state, state_n;
    logic [SCENE_W-1:0] scene_n, req_scene, req_n;
    logic [DIFF_W-1:0]  diff_n;
    logic [3:0]         pal_idx, pal_n;
    logic               ml_q, btn_q, vb_q, live;
    logic               click, btn_edge, vb_rise;
    logic               hit;
    int                 hit_row;
    int                 sel;

    // live holds edges off for the first cycle after reset, so a level that
    // was already high across release is absorbed into ml_q/btn_q first.
    assign click    = live & mouse_left & ~ml_q;
    assign btn_edge = live & button & ~btn_q;
    assign vb_rise  = vblnk_in & ~vb_q;

    always_comb begin
        hit     = 1'b0;
        hit_row = 0;
        for (int k = 0; k < N_ROWS; k++) begin
            if (row_hit(int'(xpos), int'(ypos), k)) begin
                hit     = 1'b1;
                hit_row = k;
            end
        end
    end

    always_comb begin
        state_n = state;
        req_n   = req_scene;
        scene_n = scene;
        diff_n  = difficulty;
        pal_n   = pal_idx;
        case (state)
            IDLE: begin
                if (int'(scene) == MENU) begin
                    if (click && hit) begin
                        case (hit_row)
                            0: begin
                                req_n   = SCENE_W'(GAME);
                                state_n = PEND;
                            end
                            1: diff_n = (int'(difficulty) == N_DIFF-1) ? '0 : difficulty + 1'b1;
                            2: pal_n  = (int'(pal_idx) == N_PAL-1) ? 4'd0 : pal_idx + 4'd1;
                            default: begin
                                req_n   = SCENE_W'(hit_row - 1);
                                state_n = PEND;
                            end
                        endcase
                    end
                end else if (btn_edge) begin
                    req_n   = SCENE_W'(MENU);
                    state_n = PEND;
                end
            end
            PEND: begin
                if (vb_rise) begin
                    scene_n = req_scene;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sel = (int'(scene) < N_SCENES) ? int'(scene) : MENU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scene      <= '0;
            req_scene  <= '0;
            difficulty <= '0;
            pal_idx    <= '0;
            ml_q       <= 1'b0;
            btn_q      <= 1'b0;
            vb_q       <= 1'b0;
            live       <= 1'b0;
            rgb_out    <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            scene_chg  <= 1'b0;
        end else begin
            state      <= state_n;
            scene      <= scene_n;
            req_scene  <= req_n;
            difficulty <= diff_n;
            pal_idx    <= pal_n;
            ml_q       <= mouse_left;
            btn_q      <= button;
            vb_q       <= vblnk_in;
            live       <= 1'b1;
            rgb_out    <= rgb_bus[sel*RGB_W +: RGB_W];
            vsync_out  <= vsync_bus[sel];
            hsync_out  <= hsync_bus[sel];
            scene_chg  <= (scene_n != scene);
        end
    end

    scene_palette_rom #(
        .N_PAL (N_PAL),
        .RGB_W (RGB_W)
    ) u_palette (
        .idx    (pal_idx),
        .color1 (color1),
        .color2 (color2)
    );

endmodule
